// File: rtl/dvs_event_deframer_if.sv
// Event stream from the deframer to the gesture accelerator.
// The FIFO head is presented first-word-fall-through and accepted on valid && ready.
interface dvs_event_deframer_if;
  logic        event_valid;
  logic        event_ready;
  logic [8:0]  event_x;
  logic [8:0]  event_y;
  logic        event_polarity;
  logic [15:0] event_ts;

  modport master (
    output event_valid, event_x, event_y, event_polarity, event_ts,
    input  event_ready
  );

  modport slave (
    input  event_valid, event_x, event_y, event_polarity, event_ts,
    output event_ready
  );
endinterface

// File: rtl/dvs_event_deframer.sv
// Parses the 5-byte DVS event stream and 1-byte opcodes from the UART and queues
// complete events in a FWFT FIFO, with idle-timeout resync and saturating error counters.
module dvs_event_deframer #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int TIMEOUT_CYCLES = 12000,
  parameter int FIFO_DEPTH     = 16,
  parameter int SENSOR_RES     = 320
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic [15:0]                 ts_in,
  dvs_event_deframer_if.master        ev,
  output logic                        cmd_valid,
  output logic [1:0]                  cmd_code,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_count,
  output logic [7:0]                  range_err_count,
  output logic [7:0]                  timeout_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 2 || CLK_FREQ <= 0) begin : g_bad_timing
    $error("TIMEOUT_CYCLES must be at least 2 and CLK_FREQ positive");
  end

  typedef enum logic [2:0] {S_XHI, S_XLO, S_YHI, S_YLO, S_POL} state_t;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic        pol;
    logic [15:0] ts;
  } event_t;

  state_t           state, eff_state;
  logic [TO_W-1:0]  idle_cnt;
  logic [8:0]       x_q, y_q;
  event_t           mem [FIFO_DEPTH];
  event_t           head_q, head_next, push_data;
  logic             valid_q;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LVL_W-1:0] level_next;
  logic             timeout_hit, is_opcode, pol_byte, in_range;
  logic             pop, push, drop, range_err;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // NOTE: every variable gets a value on every path through always_comb; a missed
  // branch would otherwise infer a latch.
  always_comb begin
    timeout_hit = (state != S_XHI) && (idle_cnt == TO_LAST);
    // A byte landing on the timeout cycle is parsed as if the packet had already been dropped.
    eff_state   = timeout_hit ? S_XHI : state;
    is_opcode   = (rx_data[7:2] == 6'b111111);
    pol_byte    = rx_valid && (eff_state == S_POL);
    in_range    = (int'(x_q) < SENSOR_RES) && (int'(y_q) < SENSOR_RES);
    pop         = valid_q && ev.event_ready;
    push        = pol_byte && in_range && ((fifo_level != LVL_FULL) || pop);
    drop        = pol_byte && in_range && !push;
    range_err   = pol_byte && !in_range;
    push_data   = '{x: x_q, y: y_q, pol: rx_data[0], ts: ts_in};
    rd_next     = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_next  = fifo_level + LVL_W'(push) - LVL_W'(pop);

    // Next head: the oldest surviving entry, else the event being written, else zero.
    head_next = '0;
    if (level_next != '0) begin
      if (fifo_level > LVL_W'(pop)) head_next = mem[rd_next];
      else                          head_next = push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order; later assignments override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_XHI;
      idle_cnt        <= '0;
      x_q             <= '0;
      y_q             <= '0;
      cmd_valid       <= 1'b0;
      cmd_code        <= 2'd0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      valid_q         <= 1'b0;
      head_q          <= '0;
      drop_count      <= 8'd0;
      range_err_count <= 8'd0;
      timeout_count   <= 8'd0;
    end else begin
      cmd_valid <= 1'b0;

      if (timeout_hit) begin
        state         <= S_XHI;
        timeout_count <= sat_inc(timeout_count);
      end
      if (timeout_hit || rx_valid || state == S_XHI) idle_cnt <= '0;
      else                                           idle_cnt <= idle_cnt + TO_W'(1);

      if (rx_valid) begin
        unique case (eff_state)
          S_XHI: begin
            if (is_opcode) begin
              cmd_valid <= 1'b1;
              cmd_code  <= ~rx_data[1:0];
            end else begin
              x_q[8] <= rx_data[0];
              state  <= S_XLO;
            end
          end
          S_XLO:   begin x_q[7:0] <= rx_data;    state <= S_YHI; end
          S_YHI:   begin y_q[8]   <= rx_data[0]; state <= S_YLO; end
          S_YLO:   begin y_q[7:0] <= rx_data;    state <= S_POL; end
          S_POL:   state <= S_XHI;
          default: state <= S_XHI;
        endcase
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_next;
      fifo_level <= level_next;
      valid_q    <= (level_next != '0);
      head_q     <= head_next;

      if (drop)      drop_count      <= sat_inc(drop_count);
      if (range_err) range_err_count <= sat_inc(range_err_count);
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and level alone define
  // which entries are live, which lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign ev.event_valid    = valid_q;
  assign ev.event_x        = head_q.x;
  assign ev.event_y        = head_q.y;
  assign ev.event_polarity = head_q.pol;
  assign ev.event_ts       = head_q.ts;
endmodule

// File: tb/tb_dvs_event_deframer.sv
// Self-checking bench for dvs_event_deframer: directed packet table, multi-cycle corner
// sequences and randomized traffic against a packet-level queue model.
module tb_dvs_event_deframer;
  localparam int TO    = 40;
  localparam int DEPTH = 16;
  localparam int RES   = 320;

  typedef struct { int x; int y; int pol; int ts; } ev_t;

  typedef struct {
    logic [39:0] bytes;
    logic [15:0] ts;
    bit          accept;
    int          x;
    int          y;
    int          pol;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] ts_in;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic [4:0]  fifo_level;
  logic [7:0]  drop_count, range_err_count, timeout_count;

  dvs_event_deframer_if ev_if ();

  dvs_event_deframer #(
    .CLK_FREQ      (12_000_000),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH    (DEPTH),
    .SENSOR_RES    (RES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .ts_in          (ts_in),
    .ev             (ev_if),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count),
    .range_err_count(range_err_count),
    .timeout_count  (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: packet bytes collected so far, queued events, counters.
  logic [7:0] part [$];
  ev_t        mq [$];
  int         m_drop = 0, m_range = 0, m_timeout = 0, m_cmd_code = 0;
  bit         m_cmd_valid = 1'b0;
  int         last_byte = 0;

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic rxv, input logic [7:0] rxd, input logic rdy,
                            input logic r, input logic [15:0] ts);
    ev_t e;
    m_cmd_valid = 1'b0;
    if (r) begin
      mq.delete();
      part.delete();
      m_drop = 0; m_range = 0; m_timeout = 0; m_cmd_code = 0;
      return;
    end
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (part.size() > 0 && cyc - last_byte >= TO) begin
      part.delete();
      m_timeout = sat(m_timeout);
    end
    if (rxv) begin
      last_byte = cyc;
      if (part.size() == 0 && rxd >= 8'hFC) begin
        m_cmd_valid = 1'b1;
        m_cmd_code  = 255 - int'(rxd);
      end else begin
        part.push_back(rxd);
        if (part.size() == 5) begin
          e.x   = int'(part[0][0]) * 256 + int'(part[1]);
          e.y   = int'(part[2][0]) * 256 + int'(part[3]);
          e.pol = int'(part[4][0]);
          e.ts  = int'(ts);
          part.delete();
          if (e.x >= RES || e.y >= RES) m_range = sat(m_range);
          else if (mq.size() < DEPTH)   mq.push_back(e);
          else                          m_drop = sat(m_drop);
        end
      end
    end
  endtask

  task automatic compare_all();
    ev_t h;
    h = '{x: 0, y: 0, pol: 0, ts: 0};
    if (mq.size() > 0) h = mq[0];
    check("event_valid",     64'(ev_if.event_valid),    64'(mq.size() != 0));
    check("event_x",         64'(ev_if.event_x),        64'(h.x));
    check("event_y",         64'(ev_if.event_y),        64'(h.y));
    check("event_polarity",  64'(ev_if.event_polarity), 64'(h.pol));
    check("event_ts",        64'(ev_if.event_ts),       64'(h.ts));
    check("fifo_level",      64'(fifo_level),           64'(mq.size()));
    check("drop_count",      64'(drop_count),           64'(m_drop));
    check("range_err_count", 64'(range_err_count),      64'(m_range));
    check("timeout_count",   64'(timeout_count),        64'(m_timeout));
    check("cmd_valid",       64'(cmd_valid),            64'(m_cmd_valid));
    if (m_cmd_valid) check("cmd_code", 64'(cmd_code), 64'(m_cmd_code));
  endtask

  task automatic tick(input logic rxv, input logic [7:0] rxd, input logic rdy,
                      input logic r, input logic [15:0] ts);
    rx_valid          = rxv;
    rx_data           = rxd;
    ev_if.event_ready = rdy;
    rst               = r;
    ts_in             = ts;
    cyc++;
    model_step(rxv, rxd, rdy, r, ts);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) tick(1'b0, 8'h00, rdy, 1'b0, 16'(cyc));
  endtask

  task automatic do_reset();
    tick(1'b0, 8'h00, 1'b0, 1'b1, 16'h0);
  endtask

  task automatic send_pkt(input logic [39:0] bytes, input logic [15:0] ts, input logic rdy);
    for (int k = 0; k < 4; k++) tick(1'b1, bytes[39-8*k -: 8], rdy, 1'b0, 16'h0);
    tick(1'b1, bytes[7:0], rdy, 1'b0, ts);
  endtask

  vec_t vecs [8];
  int   range_exp;
  logic rv, rr, rs;
  logic [7:0] rb;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ts_in = 16'h0; ev_if.event_ready = 1'b0;

    vecs[0] = '{bytes: 40'h01_2C_00_A0_01, ts: 16'h1234, accept: 1'b1, x: 300, y: 160, pol: 1};
    vecs[1] = '{bytes: 40'h00_FF_00_05_00, ts: 16'h0001, accept: 1'b1, x: 255, y: 5,   pol: 0};
    vecs[2] = '{bytes: 40'h01_40_00_00_00, ts: 16'h0002, accept: 1'b0, x: 0,   y: 0,   pol: 0};
    vecs[3] = '{bytes: 40'h01_3F_01_3F_FF, ts: 16'hBEEF, accept: 1'b1, x: 319, y: 319, pol: 1};
    vecs[4] = '{bytes: 40'h00_00_01_40_01, ts: 16'h0003, accept: 1'b0, x: 0,   y: 0,   pol: 0};
    vecs[5] = '{bytes: 40'h00_00_00_00_FE, ts: 16'hFFFF, accept: 1'b1, x: 0,   y: 0,   pol: 0};
    vecs[6] = '{bytes: 40'h01_FC_00_FD_FC, ts: 16'h0004, accept: 1'b0, x: 0,   y: 0,   pol: 0};
    vecs[7] = '{bytes: 40'h00_FF_01_00_03, ts: 16'h0000, accept: 1'b1, x: 255, y: 256, pol: 1};

    // Reset state
    do_reset();
    do_reset();
    check("reset event_valid", 64'(ev_if.event_valid), 64'd0);
    check("reset fifo_level",  64'(fifo_level),        64'd0);
    check("reset cmd_code",    64'(cmd_code),          64'd0);
    check("reset counters",    64'({drop_count, range_err_count, timeout_count}), 64'd0);

    // Packet table
    range_exp = 0;
    for (int i = 0; i < 8; i++) begin
      send_pkt(vecs[i].bytes, vecs[i].ts, 1'b0);
      if (vecs[i].accept) begin
        check($sformatf("vec%0d valid", i), 64'(ev_if.event_valid),    64'd1);
        check($sformatf("vec%0d x", i),     64'(ev_if.event_x),        64'(vecs[i].x));
        check($sformatf("vec%0d y", i),     64'(ev_if.event_y),        64'(vecs[i].y));
        check($sformatf("vec%0d pol", i),   64'(ev_if.event_polarity), 64'(vecs[i].pol));
        check($sformatf("vec%0d ts", i),    64'(ev_if.event_ts),       64'(vecs[i].ts));
        check($sformatf("vec%0d level", i), 64'(fifo_level),           64'd1);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 16'h0);
        check($sformatf("vec%0d popped", i), 64'(ev_if.event_valid), 64'd0);
      end else begin
        range_exp++;
        check($sformatf("vec%0d rejected", i), 64'(ev_if.event_valid),  64'd0);
        check($sformatf("vec%0d range_err", i), 64'(range_err_count), 64'(range_exp));
      end
    end

    // Opcodes in S_XHI, then a packet starting with a plain byte
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 8'(8'hFF - k), 1'b0, 1'b0, 16'h0);
      check("opcode cmd_valid", 64'(cmd_valid), 64'd1);
      check("opcode cmd_code",  64'(cmd_code),  64'(k));
    end
    idle(1, 1'b0);
    check("opcode pulse ends", 64'(cmd_valid),  64'd0);
    check("opcode no event",   64'(fifo_level), 64'd0);
    send_pkt(40'h00_FF_00_05_00, 16'h0777, 1'b0);
    check("post-opcode x", 64'(ev_if.event_x), 64'd255);
    check("post-opcode y", 64'(ev_if.event_y), 64'd5);

    // Timeout: fires on the TO-th idle cycle, not before
    do_reset();
    tick(1'b1, 8'h00, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 8'h10, 1'b0, 1'b0, 16'h0);
    idle(TO - 1, 1'b0);
    check("timeout not yet", 64'(timeout_count), 64'd0);
    idle(1, 1'b0);
    check("timeout fired", 64'(timeout_count), 64'd1);
    send_pkt(40'h00_01_00_02_01, 16'h0055, 1'b0);
    check("after timeout x", 64'(ev_if.event_x), 64'd1);
    check("after timeout y", 64'(ev_if.event_y), 64'd2);

    // Opcode arriving on the exact timeout cycle is decoded
    do_reset();
    tick(1'b1, 8'h00, 1'b0, 1'b0, 16'h0);
    idle(TO - 1, 1'b0);
    tick(1'b1, 8'hFE, 1'b0, 1'b0, 16'h0);
    check("timeout+opcode count", 64'(timeout_count), 64'd1);
    check("timeout+opcode cmd",   64'(cmd_valid),     64'd1);
    check("timeout+opcode code",  64'(cmd_code),      64'd1);

    // Overflow: 20 packets against a stalled consumer, then drain in order
    do_reset();
    for (int i = 0; i < 20; i++)
      send_pkt({8'h00, 8'(i), 8'h00, 8'(i + 1), 8'h01}, 16'(i * 100), 1'b0);
    check("overflow level", 64'(fifo_level), 64'd16);
    check("overflow drops", 64'(drop_count), 64'd4);
    for (int i = 0; i < 16; i++) begin
      check("drain x", 64'(ev_if.event_x), 64'(i));
      tick(1'b0, 8'h00, 1'b1, 1'b0, 16'h0);
    end
    check("drained valid", 64'(ev_if.event_valid), 64'd0);

    // Full FIFO with a pop on the POL cycle accepts the event
    do_reset();
    for (int i = 0; i < 16; i++)
      send_pkt({8'h00, 8'(i), 8'h00, 8'h00, 8'h00}, 16'(i), 1'b0);
    tick(1'b1, 8'h00, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 8'h64, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 8'h00, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 8'h64, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 8'h01, 1'b1, 1'b0, 16'h4242);
    check("push+pop level", 64'(fifo_level),    64'd16);
    check("push+pop drops", 64'(drop_count),    64'd0);
    check("push+pop head",  64'(ev_if.event_x), 64'd1);
    idle(15, 1'b1);
    check("push+pop tail x",  64'(ev_if.event_x),  64'd100);
    check("push+pop tail ts", 64'(ev_if.event_ts), 64'h4242);

    // Reset mid-packet with events queued and a nonzero counter
    do_reset();
    for (int i = 0; i < 3; i++) send_pkt({8'h00, 8'(i), 8'h00, 8'h09, 8'h00}, 16'h0, 1'b0);
    send_pkt(40'h01_40_00_00_00, 16'h0, 1'b0);
    tick(1'b1, 8'h00, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 8'h05, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 8'h00, 1'b0, 1'b0, 16'h0);
    do_reset();
    check("midreset valid",     64'(ev_if.event_valid), 64'd0);
    check("midreset level",     64'(fifo_level),        64'd0);
    check("midreset range_err", 64'(range_err_count),   64'd0);
    send_pkt(40'h00_07_00_08_01, 16'h0abc, 1'b0);
    check("post-reset x", 64'(ev_if.event_x), 64'd7);
    check("post-reset y", 64'(ev_if.event_y), 64'd8);

    // Saturation of range_err_count
    do_reset();
    for (int i = 0; i < 258; i++) send_pkt(40'h01_40_00_00_00, 16'h0, 1'b1);
    check("range_err saturates", 64'(range_err_count), 64'd255);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      rr = ($urandom_range(0, 9) < (i / 1000) * 2 + 1);
      rv = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       rb = 8'hFC | 8'($urandom_range(0, 3));
        1:       rb = 8'($urandom_range(0, 1));
        default: rb = 8'($urandom);
      endcase
      rs = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 299) == 0) idle(TO - 2 + $urandom_range(0, 3), rr);
      tick(rv, rb, rr, rs, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dvs_event_deframer.md
Name: dvs_event_deframer

Overview:
Sits between the UART byte receiver and dvs_gesture_accel. It parses the 5-byte DVS event packet stream and decodes single-byte command opcodes. Complete events are buffered in a first-word-fall-through FIFO with a valid/ready interface, so the accelerator can stall without losing events. It also adds an inter-byte timeout resync, a coordinate range check, and saturating error counters.

Parameters:
CLK_FREQ, 12_000_000, clock frequency in Hz; documentation only.
TIMEOUT_CYCLES, 12000, idle cycles inside a partial packet before the packet is discarded (1 ms at 12 MHz).
FIFO_DEPTH, 16, event FIFO entries; must be a power of 2 and at least 2.
SENSOR_RES, 320, legal coordinates are 0..SENSOR_RES-1.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
rx_data  in  8  received byte.
rx_valid  in  1  1-cycle strobe qualifying rx_data; there is no backpressure.
ts_in  in  16  free-running timestamp; sampled on the cycle the POL byte arrives.
event_valid  out  1  FIFO head valid (FIFO not empty).
event_ready  in  1  consumer accepts the head when event_valid && event_ready.
event_x  out  9  head X coordinate.
event_y  out  9  head Y coordinate.
event_polarity  out  1  head polarity.
event_ts  out  16  head timestamp.
cmd_valid  out  1  1-cycle pulse when a command opcode is decoded.
cmd_code  out  2  command: 0 = echo (0xFF), 1 = status (0xFE), 2 = config (0xFD), 3 = soft reset (0xFC).
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
drop_count  out  8  events lost to a full FIFO; saturates at 255.
range_err_count  out  8  events discarded for out-of-range coordinates; saturates at 255.
timeout_count  out  8  partial packets discarded by timeout; saturates at 255.

Behaviour:
- Reset values: all outputs 0, FIFO empty, parser in S_XHI, timeout counter 0. The registered head fields read 0 while empty.
- Parser FSM states: S_XHI, S_XLO, S_YHI, S_YLO, S_POL. It advances one state per rx_valid. From S_POL it returns to S_XHI.
- Opcode handling in S_XHI:
  - Bytes 0xFC..0xFF are opcodes: no state change, cmd_valid=1 and cmd_code=~rx_data[1:0] on the next cycle.
  - Any other byte stores x[8]=rx_data[0] and moves to S_XLO.
  - In every other state, 0xFC..0xFF are ordinary data bytes.
- Field capture:
  - S_XLO captures x[7:0]; S_YHI captures y[8]=rx_data[0]; S_YLO captures y[7:0].
  - S_POL captures pol=rx_data[0] and ts=ts_in on the same cycle.
- Event completion, on the S_POL byte:
  - If x>=SENSOR_RES or y>=SENSOR_RES: discard the event and increment range_err_count. No FIFO write.
  - Else, if the FIFO is not full, or it is full but a pop occurs in the same cycle: write {x,y,pol,ts}.
  - Else: discard the event and increment drop_count.
- Timeout:
  - In any state other than S_XHI, the idle counter increments each cycle without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES-1, the parser returns to S_XHI, discards the partial fields, increments timeout_count, and clears the counter.
  - A byte arriving on that same cycle is processed as the first byte in S_XHI.
  - The counter is held at 0 while in S_XHI.
- FIFO (FWFT):
  - A write at cycle N into an empty FIFO gives event_valid=1 and valid head fields at cycle N+1. Latency from the POL byte strobe to event_valid is therefore 1 cycle.
  - Head fields are stable while event_valid && !event_ready.
  - Simultaneous push and pop: fifo_level is unchanged and order is preserved.
  - Pop on empty is ignored.
  - fifo_level is exact every cycle, range 0..FIFO_DEPTH.
- Counters saturate at 255 and never wrap. Simultaneous increments of different counters are independent.
- Reset mid-packet or with the FIFO partially full: everything returns to reset values on the next edge. No event is emitted from partial state.
- The block does not act on cmd_code=3; the top-level asserts rst in response.

Test Plan:
- Bytes 0x01,0x2C,0x00,0xA0,0x01 with ts_in=0x1234 at the POL byte → one cycle later event_valid=1, x=300, y=160, pol=1, ts=0x1234; fifo_level=1.
- Bytes 0xFF, 0xFE, 0xFD, 0xFC in S_XHI → four cmd_valid pulses with codes 0, 1, 2, 3; no event; parser stays in S_XHI. Then 0x00,0xFF,0x00,0x05,0x00 → event x=255, y=5.
- Send 0x00,0x10, then stay idle for TIMEOUT_CYCLES → timeout_count=1, parser in S_XHI. A following full packet decodes correctly.
- Hold event_ready=0 and send 20 valid packets with FIFO_DEPTH=16 → fifo_level=16, drop_count=4. Then release ready → exactly the first 16 events drain in order.
- Packet with x=320 (bytes 0x01,0x40,...) → range_err_count=1, no FIFO write. With the FIFO full, a POL byte arriving on the same cycle as a pop → event accepted, drop_count unchanged.
- Assert rst after the S_YHI byte with 3 events queued → event_valid=0 and all counters 0. A following packet decodes normally.
